// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-256 key-schedule sequencer.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    KS_IDLE,
    KS_LOAD,
    KS_SETTLE,
    KS_EXPAND,
    KS_READY,
    KS_STREAM
  } ks_state_t;

  localparam int         NUM_RK  = 15;
  localparam logic [3:0] LAST_RK = 4'(NUM_RK - 1);
  localparam logic       DIR_FWD = 1'b0;
  localparam logic       DIR_REV = 1'b1;

endpackage

// File: rtl/aes_rk_stage.sv
// Masked round-key output register: loads on demand, holds while the consumer stalls.
module aes_rk_stage #(
  parameter int SHARES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_i,
  input  logic [SHARES-1:0][127:0] w_i,
  input  logic [3:0]               idx_i,
  input  logic                     last_i,
  input  logic                     ready_i,
  output logic [SHARES-1:0][127:0] rk_o,
  output logic [3:0]               idx_o,
  output logic                     last_o,
  output logic                     valid_o
);

  logic [127:0] rk_reg [SHARES];
  logic [3:0]   idx_reg;
  logic         last_reg;
  logic         valid_reg;

  // Each share gets its own register so masks never mix inside this stage.
  generate
    for (genvar gi = 0; gi < SHARES; gi++) begin : g_share
      always_ff @(posedge clk) begin
        if (reset) begin
          rk_reg[gi] <= '0;
        end else if (load_i) begin
          rk_reg[gi] <= w_i[gi];
        end
      end
      assign rk_o[gi] = rk_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg   <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else if (load_i) begin
      idx_reg   <= idx_i;
      last_reg  <= last_i;
      valid_reg <= 1'b1;
    end else if (ready_i) begin
      valid_reg <= 1'b0;
    end
  end

  assign idx_o   = idx_reg;
  assign last_o  = last_reg;
  assign valid_o = valid_reg;

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// Sequencer for the masked AES-256 key expansion: loads a shared key, waits for the
// engine with a timeout, then streams the 15 round keys forward or reverse.
module aes256_key_sched_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int SHARES  = 3,
  parameter int TIMEOUT = 511
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SHARES-1:0][255:0] key_i,
  input  logic                     key_valid_i,
  output logic                     key_ready_o,
  output logic                     key_loaded_o,
  output logic                     ke_err_o,
  output logic                     ke_enable_o,
  output logic [SHARES-1:0][255:0] ke_key_o,
  output logic                     ke_kvalid_o,
  output logic [3:0]               ke_addr_o,
  input  logic [SHARES-1:0][127:0] ke_w_i,
  input  logic                     ke_valid_i,
  input  logic                     start_i,
  input  logic                     dir_i,
  output logic                     start_ready_o,
  output logic [SHARES-1:0][127:0] rk_o,
  output logic [3:0]               rk_idx_o,
  output logic                     rk_valid_o,
  input  logic                     rk_ready_i,
  output logic                     rk_last_o
);

  localparam logic [8:0] TIMER_LAST = 9'(TIMEOUT - 1);

  ks_state_t                state_reg, state_next;
  logic [8:0]               timer_reg, timer_next;
  logic [3:0]               cursor_reg, cursor_next;
  logic                     dir_reg, dir_next;
  logic                     done_reg, done_next;
  logic                     err_reg, err_next;
  logic [SHARES-1:0][255:0] key_reg;

  logic key_hs;
  logic rk_load;
  logic at_term;
  logic beat_free;

  assign key_hs    = key_valid_i & key_ready_o;
  assign beat_free = ~rk_valid_o | rk_ready_i;
  assign at_term   = (cursor_reg == ((dir_reg == DIR_REV) ? 4'd0 : LAST_RK));
  // done_reg marks that the terminal index has already been handed to the stage.
  assign rk_load   = (state_reg == KS_STREAM) & ~done_reg & beat_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= KS_IDLE;
      timer_reg  <= '0;
      cursor_reg <= '0;
      dir_reg    <= DIR_FWD;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      key_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      cursor_reg <= cursor_next;
      dir_reg    <= dir_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      if (key_hs) begin
        key_reg <= key_i;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    cursor_next = cursor_reg;
    dir_next    = dir_reg;
    done_next   = done_reg;
    err_next    = err_reg;
    if (key_hs) begin
      err_next = 1'b0;
    end
    case (state_reg)
      KS_IDLE: begin
        if (key_valid_i) state_next = KS_LOAD;
      end
      KS_LOAD: begin
        timer_next = '0;
        state_next = KS_SETTLE;
      end
      // The engine's done flag may still be high from the previous key here.
      KS_SETTLE: state_next = KS_EXPAND;
      KS_EXPAND: begin
        if (ke_valid_i) begin
          state_next = KS_READY;
        end else if (timer_reg == TIMER_LAST) begin
          state_next = KS_IDLE;
          err_next   = 1'b1;
        end else begin
          timer_next = timer_reg + 9'd1;
        end
      end
      KS_READY: begin
        if (key_valid_i) begin
          state_next = KS_LOAD;
        end else if (start_i) begin
          state_next  = KS_STREAM;
          dir_next    = dir_i;
          cursor_next = (dir_i == DIR_FWD) ? 4'd0 : LAST_RK;
          done_next   = 1'b0;
        end
      end
      KS_STREAM: begin
        if (rk_load) begin
          if (at_term) begin
            done_next = 1'b1;
          end else if (dir_reg == DIR_REV) begin
            cursor_next = cursor_reg - 4'd1;
          end else begin
            cursor_next = cursor_reg + 4'd1;
          end
        end
        if (done_reg & beat_free) state_next = KS_READY;
      end
      default: state_next = KS_IDLE;
    endcase
  end

  always_comb begin
    key_ready_o   = 1'b0;
    key_loaded_o  = 1'b0;
    ke_enable_o   = 1'b0;
    ke_kvalid_o   = 1'b0;
    start_ready_o = 1'b0;
    ke_addr_o     = 4'd0;
    case (state_reg)
      KS_IDLE:   key_ready_o = 1'b1;
      KS_LOAD: begin
        ke_enable_o = 1'b1;
        ke_kvalid_o = 1'b1;
      end
      KS_SETTLE: ke_enable_o = 1'b1;
      KS_EXPAND: ke_enable_o = 1'b1;
      KS_READY: begin
        key_ready_o   = 1'b1;
        key_loaded_o  = 1'b1;
        start_ready_o = 1'b1;
      end
      KS_STREAM: begin
        key_loaded_o = 1'b1;
        ke_addr_o    = cursor_reg;
      end
      default: ;
    endcase
  end

  assign ke_err_o = err_reg;
  assign ke_key_o = key_reg;

  aes_rk_stage #(
    .SHARES (SHARES)
  ) u_rk_stage (
    .clk     (clk),
    .reset   (reset),
    .load_i  (rk_load),
    .w_i     (ke_w_i),
    .idx_i   (cursor_reg),
    .last_i  (at_term),
    .ready_i (rk_ready_i),
    .rk_o    (rk_o),
    .idx_o   (rk_idx_o),
    .last_o  (rk_last_o),
    .valid_o (rk_valid_o)
  );

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Bench for aes256_key_sched_ctrl: AES-256 expansion engine model plus stream scoreboard.
module tb_aes256_key_sched_ctrl;

  localparam int SHARES  = 3;
  localparam int ENG_LAT = 5;
  localparam logic [255:0] FIPS_KEY =
    256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [127:0] FIPS_RK0  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] FIPS_RK2  = 128'ha573c29f_a176c498_a97fce93_a572c09c;
  localparam logic [127:0] FIPS_RK14 = 128'h24fc79cc_bf0979e9_371ac23c_6d68de36;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [SHARES-1:0][255:0] key_i;
  logic                     key_valid_i;
  logic                     key_ready_o, key_loaded_o, ke_err_o, ke_enable_o, ke_kvalid_o;
  logic [SHARES-1:0][255:0] ke_key_o;
  logic [3:0]               ke_addr_o;
  logic [SHARES-1:0][127:0] ke_w_i;
  logic                     ke_valid_i;
  logic                     start_i, dir_i, start_ready_o;
  logic [SHARES-1:0][127:0] rk_o;
  logic [3:0]               rk_idx_o;
  logic                     rk_valid_o, rk_ready_i, rk_last_o;

  int checks = 0;
  int errors = 0;

  aes256_key_sched_ctrl #(.SHARES(SHARES), .TIMEOUT(511)) dut (
    .clk(clk), .reset(reset), .key_i(key_i), .key_valid_i(key_valid_i),
    .key_ready_o(key_ready_o), .key_loaded_o(key_loaded_o), .ke_err_o(ke_err_o),
    .ke_enable_o(ke_enable_o), .ke_key_o(ke_key_o), .ke_kvalid_o(ke_kvalid_o),
    .ke_addr_o(ke_addr_o), .ke_w_i(ke_w_i), .ke_valid_i(ke_valid_i),
    .start_i(start_i), .dir_i(dir_i), .start_ready_o(start_ready_o),
    .rk_o(rk_o), .rk_idx_o(rk_idx_o), .rk_valid_o(rk_valid_o),
    .rk_ready_i(rk_ready_i), .rk_last_o(rk_last_o)
  );

  always #5 clk = ~clk;

  // ---------------- AES-256 reference key expansion ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] k, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0)      t = subword({t[23:0], t[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
      else if (i % 8 == 4) t = subword(t);
      w[i] = w[i-8] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] rc128(input logic [SHARES-1:0][127:0] v);
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < SHARES; i++) s = s ^ v[i];
    return s;
  endfunction

  function automatic logic [255:0] rc256(input logic [SHARES-1:0][255:0] v);
    logic [255:0] s;
    s = '0;
    for (int i = 0; i < SHARES; i++) s = s ^ v[i];
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- expansion engine model (stimulus side) ----------------
  logic [SHARES-1:0][127:0] eng_w [16];
  bit   eng_done = 1'b0;
  int   eng_cnt  = 0;
  bit   stuck    = 1'b0;
  logic [255:0] eng_key;
  logic [127:0] eng_m1, eng_m2, eng_rk;

  assign ke_valid_i = eng_done;
  assign ke_w_i     = eng_w[ke_addr_o];

  // Done stays stale-high across a new load until the engine restarts its count.
  always @(posedge clk) begin
    if (ke_kvalid_o) begin
      eng_key = rc256(ke_key_o);
      for (int r = 0; r < 15; r++) begin
        eng_m1 = rnd128();
        eng_m2 = rnd128();
        eng_rk = round_key(eng_key, r);
        eng_w[r] <= {eng_m2, eng_m1, eng_rk ^ eng_m1 ^ eng_m2};
      end
      eng_cnt <= ENG_LAT;
    end else if (eng_cnt != 0) begin
      eng_cnt  <= eng_cnt - 1;
      eng_done <= (eng_cnt == 1) && !stuck;
    end
  end

  // ---------------- checking ----------------
  logic [127:0] model_rk [15];
  int           exp_q [$];
  int           log_idx [$];
  logic [127:0] log_data [$];
  int           kv_count = 0;
  bit           kv_prev = 1'b0;
  bit           hold_prev = 1'b0;
  logic [388:0] prev_beat;

  task automatic chk(input string nm, input logic [767:0] got, input logic [767:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, exp);
    end else begin
      $display("check %s ok value %0h", nm, got);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got timeout required event", nm);
  endtask

  always @(negedge clk) begin
    if (ke_kvalid_o) begin
      checks++;
      if (kv_prev) begin
        errors++;
        $display("FAIL kvalid_pulse got multi-cycle strobe required single cycle");
      end else begin
        kv_count++;
      end
    end
    kv_prev = ke_kvalid_o;
    if (!reset && rk_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat got idx %0d required no beat", rk_idx_o);
      end else begin
        chk("rk_idx", rk_idx_o, exp_q[0]);
        if (exp_q[0] >= 0 && exp_q[0] < 15) chk("rk_data", rc128(rk_o), model_rk[exp_q[0]]);
        chk("rk_last", rk_last_o, exp_q.size() == 1);
      end
      chk("busy_no_ready", {key_ready_o, start_ready_o}, 2'b00);
      if (hold_prev) chk("rk_hold", {rk_o, rk_idx_o, rk_last_o}, prev_beat);
      if (rk_ready_i && exp_q.size() != 0) begin
        log_idx.push_back(int'(rk_idx_o));
        log_data.push_back(rc128(rk_o));
        exp_q.pop_front();
      end
    end
    hold_prev = !reset && rk_valid_o && !rk_ready_i;
    prev_beat = {rk_o, rk_idx_o, rk_last_o};
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_key(input logic [255:0] k);
    logic [255:0] m1, m2;
    m1 = {rnd128(), rnd128()};
    m2 = {rnd128(), rnd128()};
    key_i = {m2, m1, k ^ m1 ^ m2};
    key_valid_i = 1'b1;
    for (int r = 0; r < 15; r++) model_rk[r] = round_key(k, r);
  endtask

  task automatic offer_key(input logic [255:0] k);
    int n;
    n = 0;
    while (!key_ready_o && n < 50) begin tick(); n++; end
    if (n >= 50) fail("key_ready_wait");
    drive_key(k);
    tick();
    key_valid_i = 1'b0;
  endtask

  task automatic wait_loaded();
    int n;
    n = 0;
    while (!key_loaded_o && n < 200) begin tick(); n++; end
    if (n >= 200) fail("load_wait");
  endtask

  task automatic begin_stream(input logic dir);
    chk("start_ready", start_ready_o, 1'b1);
    log_idx.delete();
    log_data.delete();
    dir_i = dir;
    start_i = 1'b1;
    for (int i = 0; i < 15; i++) exp_q.push_back(dir ? 14 - i : i);
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_stream(input logic dir, input bit toggle);
    int n;
    begin_stream(dir);
    n = 0;
    while ((exp_q.size() != 0 || rk_valid_o) && n < 200) begin
      if (toggle) rk_ready_i = ~rk_ready_i;
      tick();
      n++;
    end
    rk_ready_i = 1'b1;
    if (n >= 200) fail("stream_wait");
    chk("beat_count", log_idx.size(), 15);
    chk("ready_after_stream", start_ready_o, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kv0, en, n;
    logic [255:0] k5, k6;
    reset = 1'b1; key_i = '0; key_valid_i = 1'b0; start_i = 1'b0; dir_i = 1'b0; rk_ready_i = 1'b1;
    build_sbox();
    chk("pin_sbox0", sbox[0], 8'h63);
    chk("pin_sbox1", sbox[1], 8'h7c);
    chk("pin_rk0", round_key(FIPS_KEY, 0), FIPS_RK0);
    chk("pin_rk2", round_key(FIPS_KEY, 2), FIPS_RK2);
    chk("pin_rk14", round_key(FIPS_KEY, 14), FIPS_RK14);
    repeat (3) tick();
    reset = 1'b0;

    // 1: reset state
    chk("rst_key_ready", key_ready_o, 1'b1);
    chk("rst_rk_valid", rk_valid_o, 1'b0);
    chk("rst_kvalid", ke_kvalid_o, 1'b0);
    chk("rst_loaded", key_loaded_o, 1'b0);
    chk("rst_err", ke_err_o, 1'b0);
    chk("rst_rk", rk_o, '0);
    chk("rst_ke_key", ke_key_o, '0);

    // 2: forward stream of FIPS key
    offer_key(FIPS_KEY);
    chk("ke_key_shares", rc256(ke_key_o), FIPS_KEY);
    wait_loaded();
    run_stream(1'b0, 1'b0);
    chk("fwd_first_idx", log_idx[0], 0);
    chk("fwd_first_data", log_data[0], FIPS_RK0);
    chk("fwd_last_idx", log_idx[14], 14);
    chk("fwd_last_data", log_data[14], FIPS_RK14);

    // 3: reverse stream
    run_stream(1'b1, 1'b0);
    chk("rev_first_idx", log_idx[0], 14);
    chk("rev_first_data", log_data[0], FIPS_RK14);
    chk("rev_last_idx", log_idx[14], 0);
    chk("rev_last_data", log_data[14], FIPS_RK0);

    // 4: consumer stalls every other cycle
    run_stream(1'b0, 1'b1);
    for (int i = 0; i < 15 && i < log_idx.size(); i++) chk("stall_order", log_idx[i], i);

    // 5: key and start together in READY -> reload wins
    k5 = {rnd128(), rnd128()};
    kv0 = kv_count;
    drive_key(k5);
    start_i = 1'b1;
    dir_i = 1'b0;
    tick();
    key_valid_i = 1'b0;
    start_i = 1'b0;
    chk("reload_loaded_drop", key_loaded_o, 1'b0);
    chk("reload_kvalid", ke_kvalid_o, 1'b1);
    tick();
    tick();
    chk("settle_ignores_valid", key_loaded_o, 1'b0);
    wait_loaded();
    chk("one_kvalid_pulse", kv_count - kv0, 1);
    chk("no_stray_stream", rk_valid_o, 1'b0);
    run_stream(1'b0, 1'b0);

    // 6: expansion timeout, recovery, reset mid-stream
    stuck = 1'b1;
    k6 = {rnd128(), rnd128()};
    offer_key(k6);
    en = 0;
    n = 0;
    while (!ke_err_o && n < 700) begin
      if (ke_enable_o) en++;
      tick();
      n++;
    end
    if (n >= 700) fail("timeout_wait");
    chk("timeout_err", ke_err_o, 1'b1);
    chk("timeout_enable_cycles", en, 513);
    chk("timeout_idle", key_ready_o, 1'b1);
    chk("timeout_not_loaded", key_loaded_o, 1'b0);
    stuck = 1'b0;
    offer_key(FIPS_KEY);
    chk("err_cleared", ke_err_o, 1'b0);
    wait_loaded();
    begin_stream(1'b0);
    n = 0;
    while (log_idx.size() < 7 && n < 100) begin tick(); n++; end
    if (n >= 100) fail("beat7_wait");
    reset = 1'b1;
    tick();
    exp_q.delete();
    reset = 1'b0;
    chk("rst_mid_valid", rk_valid_o, 1'b0);
    chk("rst_mid_key_ready", key_ready_o, 1'b1);
    chk("rst_mid_loaded", key_loaded_o, 1'b0);
    chk("rst_mid_enable", ke_enable_o, 1'b0);
    tick();
    chk("rst_mid_stays_idle", rk_valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
